// File: rtl/trap_ctrl.sv
// Trap controller: picks the winning interrupt or oldest excepting commit slot,
// gates retirement, and holds a registered trap record until the redirect is accepted.
//   state | meaning
//   IDLE  | commits flow; inputs evaluated for a new trap
//   HOLD  | trap record valid, waiting for i_trap_rdy; nothing retires
//   FLUSH | one cycle after acceptance; nothing retires
module trap_ctrl #(
    parameter int COMMIT_WIDTH = 4,
    parameter int XLEN         = 64,
    parameter int CAUSE_W      = 6
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [COMMIT_WIDTH-1:0]         i_commit_vld,
    input  logic [COMMIT_WIDTH-1:0]         i_commit_exc,
    input  logic [COMMIT_WIDTH*CAUSE_W-1:0] i_commit_cause,
    input  logic [COMMIT_WIDTH*XLEN-1:0]    i_commit_pc,
    input  logic [COMMIT_WIDTH*XLEN-1:0]    i_commit_tval,
    input  logic [XLEN-1:0]                 i_next_pc,
    input  logic [11:0]                     i_mip,
    input  logic [11:0]                     i_mie,
    input  logic                            i_mstatus_mie,
    input  logic [XLEN-1:0]                 i_mtvec,
    input  logic                            i_trap_rdy,
    output logic [COMMIT_WIDTH-1:0]         o_commit_mask,
    output logic                            o_trap_vld,
    output logic [XLEN-1:0]                 o_trap_epc,
    output logic [XLEN-1:0]                 o_trap_cause,
    output logic [XLEN-1:0]                 o_trap_tval,
    output logic [XLEN-1:0]                 o_trap_target,
    output logic [31:0]                     o_trap_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    // Only the machine/supervisor software, timer and external bits exist.
    localparam logic [11:0] INT_USED = 12'hAAA;

    logic [1:0]              r_state;
    logic [XLEN-1:0]         r_epc;
    logic [XLEN-1:0]         r_cause;
    logic [XLEN-1:0]         r_tval;
    logic [XLEN-1:0]         r_target;
    logic [31:0]             r_cnt;

    logic [11:0]             w_int_pend;
    logic                    w_int_any;
    logic [3:0]              w_int_code;
    logic [COMMIT_WIDTH-1:0] w_exc_hit;
    logic                    w_exc_any;
    logic [COMMIT_WIDTH-1:0] w_older;
    logic [XLEN-1:0]         w_exc_pc;
    logic [XLEN-1:0]         w_exc_tval;
    logic [CAUSE_W-1:0]      w_exc_cause;
    logic                    w_trap;
    logic [XLEN-1:0]         w_base;
    logic [XLEN-1:0]         w_cap_epc;
    logic [XLEN-1:0]         w_cap_cause;
    logic [XLEN-1:0]         w_cap_tval;
    logic [XLEN-1:0]         w_cap_target;

    assign w_int_pend = i_mip & i_mie & {12{i_mstatus_mie}} & INT_USED;
    assign w_int_any  = |w_int_pend;
    assign w_exc_hit  = i_commit_vld & i_commit_exc;

    always_comb begin
        w_int_code = 4'd0;
        if (w_int_pend[11])     w_int_code = 4'd11;
        else if (w_int_pend[3]) w_int_code = 4'd3;
        else if (w_int_pend[7]) w_int_code = 4'd7;
        else if (w_int_pend[9]) w_int_code = 4'd9;
        else if (w_int_pend[1]) w_int_code = 4'd1;
        else if (w_int_pend[5]) w_int_code = 4'd5;
    end

    // Scan youngest to oldest so the last hit written is the oldest one.
    always_comb begin
        w_exc_any   = 1'b0;
        w_older     = '0;
        w_exc_pc    = '0;
        w_exc_tval  = '0;
        w_exc_cause = '0;
        for (int i = COMMIT_WIDTH - 1; i >= 0; i--) begin
            if (w_exc_hit[i]) begin
                w_exc_any   = 1'b1;
                w_exc_pc    = i_commit_pc[i*XLEN +: XLEN];
                w_exc_tval  = i_commit_tval[i*XLEN +: XLEN];
                w_exc_cause = i_commit_cause[i*CAUSE_W +: CAUSE_W];
                w_older     = '0;
                for (int j = 0; j < i; j++) w_older[j] = 1'b1;
            end
        end
    end

    assign w_trap = (r_state == S_IDLE) && (w_int_any || w_exc_any);
    assign w_base = {i_mtvec[XLEN-1:2], 2'b00};

    always_comb begin
        if (w_int_any) begin
            w_cap_epc   = i_commit_vld[0] ? i_commit_pc[XLEN-1:0] : i_next_pc;
            w_cap_cause = {1'b1, {(XLEN-5){1'b0}}, w_int_code};
            w_cap_tval  = '0;
            if (i_mtvec[1:0] == 2'b01)
                w_cap_target = w_base + {{(XLEN-6){1'b0}}, w_int_code, 2'b00};
            else
                w_cap_target = w_base;
        end else begin
            w_cap_epc    = w_exc_pc;
            w_cap_cause  = {{(XLEN-CAUSE_W){1'b0}}, w_exc_cause};
            w_cap_tval   = w_exc_tval;
            w_cap_target = w_base;
        end
    end

    always_comb begin
        o_commit_mask = '0;
        if (r_state == S_IDLE) begin
            if (w_int_any)      o_commit_mask = '0;
            else if (w_exc_any) o_commit_mask = i_commit_vld & w_older;
            else                o_commit_mask = i_commit_vld;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_epc    <= '0;
            r_cause  <= '0;
            r_tval   <= '0;
            r_target <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_trap) begin
                        r_state  <= S_HOLD;
                        r_epc    <= w_cap_epc;
                        r_cause  <= w_cap_cause;
                        r_tval   <= w_cap_tval;
                        r_target <= w_cap_target;
                    end
                end
                S_HOLD: begin
                    if (i_trap_rdy) begin
                        r_state <= S_FLUSH;
                        r_cnt   <= r_cnt + 32'd1;
                    end
                end
                S_FLUSH: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_trap_vld    = (r_state == S_HOLD);
    assign o_trap_epc    = r_epc;
    assign o_trap_cause  = r_cause;
    assign o_trap_tval   = r_tval;
    assign o_trap_target = r_target;
    assign o_trap_cnt    = r_cnt;

endmodule
